// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_pkg
// Purpose  : Shared opcodes, operation codes, decoded-packet struct and
//            immediate-extraction helpers for the decode stage.
// Revision : 1.0 - initial release
// ============================================================================
package decode_pkg;

   // Immediates are always built at full RV64 width and truncated by the user.
   localparam int IMM_W = 64;

   localparam logic [6:0] OPC_LOAD      = 7'h03;
   localparam logic [6:0] OPC_MISC_MEM  = 7'h0f;
   localparam logic [6:0] OPC_OP_IMM    = 7'h13;
   localparam logic [6:0] OPC_AUIPC     = 7'h17;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'h1b;
   localparam logic [6:0] OPC_STORE     = 7'h23;
   localparam logic [6:0] OPC_OP        = 7'h33;
   localparam logic [6:0] OPC_LUI       = 7'h37;
   localparam logic [6:0] OPC_OP_32     = 7'h3b;
   localparam logic [6:0] OPC_BRANCH    = 7'h63;
   localparam logic [6:0] OPC_JALR      = 7'h67;
   localparam logic [6:0] OPC_JAL       = 7'h6f;
   localparam logic [6:0] OPC_SYSTEM    = 7'h73;

   typedef enum logic [10:0] {
      OP_NONE  = 11'd0,
      OP_LUI   = 11'd1,  OP_AUIPC = 11'd2,  OP_JAL   = 11'd3,  OP_JALR  = 11'd4,
      OP_BEQ   = 11'd5,  OP_BNE   = 11'd6,  OP_BLT   = 11'd7,  OP_BGE   = 11'd8,
      OP_BLTU  = 11'd9,  OP_BGEU  = 11'd10,
      OP_LB    = 11'd11, OP_LH    = 11'd12, OP_LW    = 11'd13, OP_LD    = 11'd14,
      OP_LBU   = 11'd15, OP_LHU   = 11'd16, OP_LWU   = 11'd17,
      OP_SB    = 11'd18, OP_SH    = 11'd19, OP_SW    = 11'd20, OP_SD    = 11'd21,
      OP_ADDI  = 11'd22, OP_SLTI  = 11'd23, OP_SLTIU = 11'd24, OP_XORI  = 11'd25,
      OP_ORI   = 11'd26, OP_ANDI  = 11'd27, OP_SLLI  = 11'd28, OP_SRLI  = 11'd29,
      OP_SRAI  = 11'd30,
      OP_ADD   = 11'd31, OP_SUB   = 11'd32, OP_SLL   = 11'd33, OP_SLT   = 11'd34,
      OP_SLTU  = 11'd35, OP_XOR   = 11'd36, OP_SRL   = 11'd37, OP_SRA   = 11'd38,
      OP_OR    = 11'd39, OP_AND   = 11'd40,
      OP_ADDIW = 11'd41, OP_SLLIW = 11'd42, OP_SRLIW = 11'd43, OP_SRAIW = 11'd44,
      OP_ADDW  = 11'd45, OP_SUBW  = 11'd46, OP_SLLW  = 11'd47, OP_SRLW  = 11'd48,
      OP_SRAW  = 11'd49,
      OP_FENCE = 11'd50, OP_ECALL = 11'd51,
      OP_MUL   = 11'd52, OP_MULH  = 11'd53, OP_MULHSU = 11'd54, OP_MULHU = 11'd55,
      OP_DIV   = 11'd56, OP_DIVU  = 11'd57, OP_REM   = 11'd58, OP_REMU  = 11'd59,
      OP_MULW  = 11'd60, OP_DIVW  = 11'd61, OP_DIVUW = 11'd62, OP_REMW  = 11'd63,
      OP_REMUW = 11'd64
   } operation_e;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   typedef struct packed {
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic [IMM_W-1:0] imm;
      operation_e       operation;
      logic             regwrite;
      logic             memread;
      logic             memwrite;
      logic             is_ecall;
      logic             is_serial;
      logic             illegal;
   } decoded_t;

   function automatic logic [IMM_W-1:0] imm_i(input logic [31:0] ins);
      return {{(IMM_W-12){ins[31]}}, ins[31:20]};
   endfunction

   function automatic logic [IMM_W-1:0] imm_s(input logic [31:0] ins);
      return {{(IMM_W-12){ins[31]}}, ins[31:25], ins[11:7]};
   endfunction

   function automatic logic [IMM_W-1:0] imm_b(input logic [31:0] ins);
      return {{(IMM_W-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   endfunction

   function automatic logic [IMM_W-1:0] imm_j(input logic [31:0] ins);
      return {{(IMM_W-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
   endfunction

   function automatic logic [IMM_W-1:0] imm_u(input logic [31:0] ins);
      return {{(IMM_W-32){ins[31]}}, ins[31:12], 12'b0};
   endfunction

endpackage
`default_nettype wire

// File: rtl/decode_comb.sv
`default_nettype none
// ============================================================================
// Module   : decode_comb
// Purpose  : Purely combinational RV32/RV64 integer instruction decoder.
//            Build option RV_M_EN enables the multiply/divide encodings;
//            without it they decode as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module decode_comb
   import decode_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0] instrux_i,
   output decoded_t    dec_o
);

   localparam int SHAMT_W = $clog2(XLEN);
   localparam bit RV64    = (XLEN == 64);

   logic [6:0]       w_opc;
   logic [6:0]       w_f7;
   logic [5:0]       w_f6;
   logic [2:0]       w_f3;
   logic [4:0]       w_rs1;
   logic [4:0]       w_rs2;
   logic [4:0]       w_rd;
   logic [IMM_W-1:0] w_shamt;
   logic             w_ill;
   decoded_t         w_dec;

   assign w_opc   = instrux_i[6:0];
   assign w_f7    = instrux_i[31:25];
   assign w_f6    = instrux_i[31:26];
   assign w_f3    = instrux_i[14:12];
   assign w_rs1   = instrux_i[19:15];
   assign w_rs2   = instrux_i[24:20];
   assign w_rd    = instrux_i[11:7];
   assign w_shamt = {{(IMM_W-SHAMT_W){1'b0}}, instrux_i[20 +: SHAMT_W]};

   // Decode opcode/funct fields; any unrecognised encoding collapses to an illegal packet.
   always_comb begin
      w_dec = '0;
      w_ill = 1'b0;
      case (w_opc)
         OPC_LUI, OPC_AUIPC: begin
            w_dec.operation = (w_opc == OPC_LUI) ? OP_LUI : OP_AUIPC;
            w_dec.rd        = w_rd;
            w_dec.imm       = imm_u(instrux_i);
            w_dec.regwrite  = 1'b1;
         end
         OPC_JAL: begin
            w_dec.operation = OP_JAL;
            w_dec.rd        = w_rd;
            w_dec.imm       = imm_j(instrux_i);
            w_dec.regwrite  = 1'b1;
         end
         OPC_JALR: begin
            w_dec.operation = OP_JALR;
            w_dec.rd        = w_rd;
            w_dec.rs1       = w_rs1;
            w_dec.imm       = imm_i(instrux_i);
            w_dec.regwrite  = 1'b1;
            if (w_f3 != 3'd0) w_ill = 1'b1;
         end
         OPC_BRANCH: begin
            w_dec.rs1 = w_rs1;
            w_dec.rs2 = w_rs2;
            w_dec.imm = imm_b(instrux_i);
            case (w_f3)
               3'd0:    w_dec.operation = OP_BEQ;
               3'd1:    w_dec.operation = OP_BNE;
               3'd4:    w_dec.operation = OP_BLT;
               3'd5:    w_dec.operation = OP_BGE;
               3'd6:    w_dec.operation = OP_BLTU;
               3'd7:    w_dec.operation = OP_BGEU;
               default: w_ill = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            w_dec.rd        = w_rd;
            w_dec.rs1       = w_rs1;
            w_dec.imm       = imm_i(instrux_i);
            w_dec.regwrite  = 1'b1;
            w_dec.memread   = 1'b1;
            w_dec.is_serial = 1'b1;
            case (w_f3)
               3'd0:    w_dec.operation = OP_LB;
               3'd1:    w_dec.operation = OP_LH;
               3'd2:    w_dec.operation = OP_LW;
               3'd3:    if (RV64) w_dec.operation = OP_LD;  else w_ill = 1'b1;
               3'd4:    w_dec.operation = OP_LBU;
               3'd5:    w_dec.operation = OP_LHU;
               3'd6:    if (RV64) w_dec.operation = OP_LWU; else w_ill = 1'b1;
               default: w_ill = 1'b1;
            endcase
         end
         OPC_STORE: begin
            w_dec.rs1       = w_rs1;
            w_dec.rs2       = w_rs2;
            w_dec.imm       = imm_s(instrux_i);
            w_dec.memwrite  = 1'b1;
            w_dec.is_serial = 1'b1;
            case (w_f3)
               3'd0:    w_dec.operation = OP_SB;
               3'd1:    w_dec.operation = OP_SH;
               3'd2:    w_dec.operation = OP_SW;
               3'd3:    if (RV64) w_dec.operation = OP_SD; else w_ill = 1'b1;
               default: w_ill = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            w_dec.rd       = w_rd;
            w_dec.rs1      = w_rs1;
            w_dec.imm      = imm_i(instrux_i);
            w_dec.regwrite = 1'b1;
            case (w_f3)
               3'd0: w_dec.operation = OP_ADDI;
               3'd2: w_dec.operation = OP_SLTI;
               3'd3: w_dec.operation = OP_SLTIU;
               3'd4: w_dec.operation = OP_XORI;
               3'd6: w_dec.operation = OP_ORI;
               3'd7: w_dec.operation = OP_ANDI;
               3'd1: begin
                  w_dec.imm = w_shamt;
                  // shamt[5] only exists on RV64; bit 25 must be clear on RV32.
                  if (w_f6 == 6'h00 && (RV64 || !instrux_i[25])) w_dec.operation = OP_SLLI;
                  else w_ill = 1'b1;
               end
               default: begin
                  w_dec.imm = w_shamt;
                  if (!RV64 && instrux_i[25])  w_ill = 1'b1;
                  else if (w_f6 == 6'h00)      w_dec.operation = OP_SRLI;
                  else if (w_f6 == 6'h10)      w_dec.operation = OP_SRAI;
                  else                         w_ill = 1'b1;
               end
            endcase
         end
         OPC_OP_IMM_32: begin
            w_dec.rd       = w_rd;
            w_dec.rs1      = w_rs1;
            w_dec.imm      = imm_i(instrux_i);
            w_dec.regwrite = 1'b1;
            if (!RV64) w_ill = 1'b1;
            else begin
               case (w_f3)
                  3'd0: w_dec.operation = OP_ADDIW;
                  3'd1: begin
                     w_dec.imm = w_shamt;
                     if (w_f7 == 7'h00) w_dec.operation = OP_SLLIW; else w_ill = 1'b1;
                  end
                  3'd5: begin
                     w_dec.imm = w_shamt;
                     if (w_f7 == 7'h00)      w_dec.operation = OP_SRLIW;
                     else if (w_f7 == 7'h20) w_dec.operation = OP_SRAIW;
                     else                    w_ill = 1'b1;
                  end
                  default: w_ill = 1'b1;
               endcase
            end
         end
         OPC_OP: begin
            w_dec.rd       = w_rd;
            w_dec.rs1      = w_rs1;
            w_dec.rs2      = w_rs2;
            w_dec.regwrite = 1'b1;
            case (w_f7)
               7'h00: begin
                  case (w_f3)
                     3'd0:    w_dec.operation = OP_ADD;
                     3'd1:    w_dec.operation = OP_SLL;
                     3'd2:    w_dec.operation = OP_SLT;
                     3'd3:    w_dec.operation = OP_SLTU;
                     3'd4:    w_dec.operation = OP_XOR;
                     3'd5:    w_dec.operation = OP_SRL;
                     3'd6:    w_dec.operation = OP_OR;
                     default: w_dec.operation = OP_AND;
                  endcase
               end
               7'h20: begin
                  case (w_f3)
                     3'd0:    w_dec.operation = OP_SUB;
                     3'd5:    w_dec.operation = OP_SRA;
                     default: w_ill = 1'b1;
                  endcase
               end
`ifdef RV_M_EN
               7'h01: begin
                  case (w_f3)
                     3'd0:    w_dec.operation = OP_MUL;
                     3'd1:    w_dec.operation = OP_MULH;
                     3'd2:    w_dec.operation = OP_MULHSU;
                     3'd3:    w_dec.operation = OP_MULHU;
                     3'd4:    w_dec.operation = OP_DIV;
                     3'd5:    w_dec.operation = OP_DIVU;
                     3'd6:    w_dec.operation = OP_REM;
                     default: w_dec.operation = OP_REMU;
                  endcase
               end
`endif
               default: w_ill = 1'b1;
            endcase
         end
         OPC_OP_32: begin
            w_dec.rd       = w_rd;
            w_dec.rs1      = w_rs1;
            w_dec.rs2      = w_rs2;
            w_dec.regwrite = 1'b1;
            if (!RV64) w_ill = 1'b1;
            else begin
               case ({w_f7, w_f3})
                  {7'h00, 3'd0}: w_dec.operation = OP_ADDW;
                  {7'h00, 3'd1}: w_dec.operation = OP_SLLW;
                  {7'h00, 3'd5}: w_dec.operation = OP_SRLW;
                  {7'h20, 3'd0}: w_dec.operation = OP_SUBW;
                  {7'h20, 3'd5}: w_dec.operation = OP_SRAW;
`ifdef RV_M_EN
                  {7'h01, 3'd0}: w_dec.operation = OP_MULW;
                  {7'h01, 3'd4}: w_dec.operation = OP_DIVW;
                  {7'h01, 3'd5}: w_dec.operation = OP_DIVUW;
                  {7'h01, 3'd6}: w_dec.operation = OP_REMW;
                  {7'h01, 3'd7}: w_dec.operation = OP_REMUW;
`endif
                  default:       w_ill = 1'b1;
               endcase
            end
         end
         OPC_MISC_MEM: begin
            if (w_f3 == 3'd0) w_dec.operation = OP_FENCE; else w_ill = 1'b1;
         end
         OPC_SYSTEM: begin
            // Only ECALL is supported; every other SYSTEM encoding traps as illegal.
            if (instrux_i[31:7] == 25'd0) begin
               w_dec.operation = OP_ECALL;
               w_dec.is_ecall  = 1'b1;
               w_dec.is_serial = 1'b1;
            end else begin
               w_ill = 1'b1;
            end
         end
         default: w_ill = 1'b1;
      endcase

      if (w_ill) begin
         w_dec         = '0;
         w_dec.illegal = 1'b1;
      end
   end

   assign dec_o = w_dec;

endmodule
`default_nettype wire

// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decode_pipe
// Purpose  : Decode stage with valid/ready handshake, one-entry skid buffer
//            and a RUN/WAIT serialisation FSM for load/store/ecall.
//            Build option RV_M_EN (passed to decode_comb) enables M-extension.
// Revision : 1.0 - initial release
// ============================================================================
module decode_pipe
   import decode_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instrux,
   input  logic [XLEN-1:0]   in_pc,
   input  logic              flush,
   input  logic              serial_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [31:0]       out_instrux,
   output logic [4:0]        out_rs1,
   output logic [4:0]        out_rs2,
   output logic [4:0]        out_rd,
   output logic [XLEN-1:0]   out_imm,
   output logic [10:0]       out_operation,
   output logic              out_regwrite,
   output logic              out_memread,
   output logic              out_memwrite,
   output logic              out_is_ecall,
   output logic              out_illegal,
   output logic              serial_busy
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instrux;
      decoded_t        dec;
   } packet_t;

   state_e  state_q, state_d;
   packet_t out_q, out_d;
   packet_t skid_q, skid_d;
   logic    out_valid_q, out_valid_d;
   logic    skid_valid_q, skid_valid_d;

   decoded_t w_dec;
   packet_t  w_new;
   logic     w_accept;
   logic     w_load_out;

   decode_comb #(
      .XLEN (XLEN)
   ) u_decode (
      .instrux_i (in_instrux),
      .dec_o     (w_dec)
   );

   assign in_ready   = (state_q == ST_RUN) && !skid_valid_q && !flush;
   assign w_accept   = in_valid && in_ready;
   assign w_load_out = !out_valid_q || out_ready;
   assign w_new      = '{pc: in_pc, instrux: in_instrux, dec: w_dec};

   // Output/skid next state: flush kills everything, skid drains before new packets.
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (w_load_out) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (w_accept) begin
            out_d       = w_new;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (w_accept) begin
         skid_d       = w_new;
         skid_valid_d = 1'b1;
      end
   end

   // Serialisation FSM next state: park in WAIT after a legal load/store/ecall.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (w_accept && w_dec.is_serial) state_d = ST_WAIT;
         ST_WAIT: if (serial_done || flush)        state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_RUN;
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_pc        = out_q.pc;
   assign out_instrux   = out_q.instrux;
   assign out_rs1       = out_q.dec.rs1;
   assign out_rs2       = out_q.dec.rs2;
   assign out_rd        = out_q.dec.rd;
   assign out_imm       = out_q.dec.imm[XLEN-1:0];
   assign out_operation = out_q.dec.operation;
   assign out_regwrite  = out_q.dec.regwrite;
   assign out_memread   = out_q.dec.memread;
   assign out_memwrite  = out_q.dec.memwrite;
   assign out_is_ecall  = out_q.dec.is_ecall;
   assign out_illegal   = out_q.dec.illegal;
   assign serial_busy   = (state_q == ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_pipe
// Purpose  : Directed bench for decode_pipe, one XLEN=64 and one XLEN=32
//            instance sharing stimulus. RV_M_EN selects the MUL expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_pipe;
   import decode_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_instrux;
   logic [63:0] in_pc;
   logic        flush;
   logic        serial_done;
   logic        out_ready;

   logic        rdy64, vld64, rw64, mr64, mw64, ec64, il64, busy64;
   logic [63:0] pc64, imm64;
   logic [31:0] ins64;
   logic [4:0]  rs1_64, rs2_64, rd64;
   logic [10:0] op64;

   logic        rdy32, vld32, rw32, mr32, mw32, ec32, il32, busy32;
   logic [31:0] pc32, imm32, ins32;
   logic [4:0]  rs1_32, rs2_32, rd32;
   logic [10:0] op32;

   decode_pipe #(.XLEN(64)) u_dut64 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
      .in_instrux(in_instrux), .in_pc(in_pc), .flush(flush), .serial_done(serial_done),
      .out_valid(vld64), .out_ready(out_ready), .out_pc(pc64), .out_instrux(ins64),
      .out_rs1(rs1_64), .out_rs2(rs2_64), .out_rd(rd64), .out_imm(imm64),
      .out_operation(op64), .out_regwrite(rw64), .out_memread(mr64),
      .out_memwrite(mw64), .out_is_ecall(ec64), .out_illegal(il64), .serial_busy(busy64)
   );

   decode_pipe #(.XLEN(32)) u_dut32 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
      .in_instrux(in_instrux), .in_pc(in_pc[31:0]), .flush(flush), .serial_done(serial_done),
      .out_valid(vld32), .out_ready(out_ready), .out_pc(pc32), .out_instrux(ins32),
      .out_rs1(rs1_32), .out_rs2(rs2_32), .out_rd(rd32), .out_imm(imm32),
      .out_operation(op32), .out_regwrite(rw32), .out_memread(mr32),
      .out_memwrite(mw32), .out_is_ecall(ec32), .out_illegal(il32), .serial_busy(busy32)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [10:0] op;
      logic [4:0]  rs1, rs2, rd;
      logic [63:0] imm;
      logic        rw, mr, mw, ec, ill, ill32;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] instr, input logic [10:0] op,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [63:0] imm, input logic rw, input logic mr,
                               input logic mw, input logic ec, input logic ill, input logic ill32);
      vec_t v;
      v.instr = instr; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm;
      v.rw = rw; v.mr = mr; v.mw = mw; v.ec = ec; v.ill = ill; v.ill32 = ill32;
      return v;
   endfunction

   function automatic vec_t mk_ill(input logic [31:0] instr);
      return mk(instr, OP_NONE, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
   endfunction

   localparam logic [31:0] ADDI_X5 = 32'hFFF08293;
   localparam logic [31:0] ADDI_X6 = 32'hFFF08313;
   localparam logic [31:0] ADDI_X7 = 32'hFFF08393;
   localparam logic [31:0] LD_X6   = 32'h00813303;

   initial begin
      logic exp_busy;

      vecs[0]  = mk(ADDI_X5,      OP_ADDI, 5'd1, 5'd0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 0, 0);
      vecs[1]  = mk(LD_X6,        OP_LD,   5'd2, 5'd0, 5'd6, 64'd8,                   1, 1, 0, 0, 0, 1);
      vecs[2]  = mk(32'hFFDFF0EF, OP_JAL,  5'd0, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0, 0, 0);
`ifdef RV_M_EN
      vecs[3]  = mk(32'h02B50533, OP_MUL,  5'd10, 5'd11, 5'd10, 64'd0,                1, 0, 0, 0, 0, 0);
`else
      vecs[3]  = mk_ill(32'h02B50533);
`endif
      vecs[4]  = mk(32'h402081B3, OP_SUB,  5'd1, 5'd2, 5'd3, 64'd0,                   1, 0, 0, 0, 0, 0);
      vecs[5]  = mk(32'hFE512E23, OP_SW,   5'd2, 5'd5, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1, 0, 0, 0);
      vecs[6]  = mk(32'h00208863, OP_BEQ,  5'd1, 5'd2, 5'd0, 64'd16,                  0, 0, 0, 0, 0, 0);
      vecs[7]  = mk(32'h800003B7, OP_LUI,  5'd0, 5'd0, 5'd7, 64'hFFFF_FFFF_8000_0000, 1, 0, 0, 0, 0, 0);
      vecs[8]  = mk(32'h43F25213, OP_SRAI, 5'd4, 5'd0, 5'd4, 64'd63,                  1, 0, 0, 0, 0, 1);
      vecs[9]  = mk_ill(32'h04109093);
      vecs[10] = mk_ill(32'h0000007F);
      vecs[11] = mk(32'h00000073, OP_ECALL, 5'd0, 5'd0, 5'd0, 64'd0,                  0, 0, 0, 1, 0, 0);
      vecs[12] = mk(32'h003100BB, OP_ADDW, 5'd2, 5'd3, 5'd1, 64'd0,                   1, 0, 0, 0, 0, 1);
      vecs[13] = mk_ill(32'h003120BB);

      reset = 1'b1; in_valid = 1'b0; in_instrux = 32'd0; in_pc = 64'd0;
      flush = 1'b0; serial_done = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset out_valid64", 64'(vld64), 64'd0);
      chk("reset out_valid32", 64'(vld32), 64'd0);
      chk("reset op64",        64'(op64),  64'd0);
      chk("reset imm64",       imm64,      64'd0);
      chk("reset pc64",        pc64,       64'd0);
      chk("reset regwrite64",  64'(rw64),  64'd0);
      chk("reset busy64",      64'(busy64), 64'd0);
      chk("reset in_ready64",  64'(rdy64), 64'd1);

      // ---------------- table-driven single-instruction decode ----------------
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         in_instrux = vecs[i].instr;
         in_pc      = 64'h1000 + 64'(i) * 64'd4;
         in_valid   = 1'b1;
         out_ready  = 1'b1;
         #1;
         chk($sformatf("v%0d in_ready64", i), 64'(rdy64), 64'd1);
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         exp_busy = (vecs[i].mr | vecs[i].mw | vecs[i].ec) & ~vecs[i].ill;
         chk($sformatf("v%0d valid64", i),    64'(vld64), 64'd1);
         chk($sformatf("v%0d pc64", i),       pc64, 64'h1000 + 64'(i) * 64'd4);
         chk($sformatf("v%0d instrux64", i),  64'(ins64), 64'(vecs[i].instr));
         chk($sformatf("v%0d op64", i),       64'(op64),   64'(vecs[i].op));
         chk($sformatf("v%0d rs1_64", i),     64'(rs1_64), 64'(vecs[i].rs1));
         chk($sformatf("v%0d rs2_64", i),     64'(rs2_64), 64'(vecs[i].rs2));
         chk($sformatf("v%0d rd64", i),       64'(rd64),   64'(vecs[i].rd));
         chk($sformatf("v%0d imm64", i),      imm64,       vecs[i].imm);
         chk($sformatf("v%0d flags64", i),    64'({rw64, mr64, mw64, ec64, il64}),
             64'({vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].ec, vecs[i].ill}));
         chk($sformatf("v%0d busy64", i),     64'(busy64), 64'(exp_busy));
         chk($sformatf("v%0d valid32", i),    64'(vld32), 64'd1);
         if (vecs[i].ill32) begin
            chk($sformatf("v%0d illegal32", i), 64'({il32, rw32, mr32, mw32}), 64'b1000);
            chk($sformatf("v%0d op32", i),      64'(op32), 64'd0);
            chk($sformatf("v%0d rd32", i),      64'(rd32), 64'd0);
            chk($sformatf("v%0d busy32", i),    64'(busy32), 64'd0);
         end else begin
            chk($sformatf("v%0d illegal32", i), 64'(il32), 64'd0);
            chk($sformatf("v%0d op32", i),      64'(op32), 64'(vecs[i].op));
            chk($sformatf("v%0d imm32", i),     64'(imm32), 64'(vecs[i].imm[31:0]));
            chk($sformatf("v%0d busy32", i),    64'(busy32), 64'(exp_busy));
         end
         serial_done = 1'b1;
         @(negedge clk);
         serial_done = 1'b0;
      end

      // ---------------- backpressure: output register + skid, strict order ----------------
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_instrux = ADDI_X5;
      #1 chk("bp accept A", 64'(rdy64), 64'd1);
      @(negedge clk);
      in_instrux = ADDI_X6;
      #1 chk("bp accept B", 64'(rdy64), 64'd1);
      @(negedge clk);
      in_instrux = ADDI_X7;
      #1;
      chk("bp blocked C",   64'(rdy64), 64'd0);
      chk("bp held rd A",   64'(rd64),  64'd5);
      @(negedge clk);
      #1;
      chk("bp stable rd A", 64'(rd64),  64'd5);
      chk("bp still blk",   64'(rdy64), 64'd0);
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("bp pop1 rd B",   64'(rd64),  64'd6);
      chk("bp ready C",     64'(rdy64), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("bp pop2 rd C",   64'(rd64),  64'd7);
      chk("bp pop2 valid",  64'(vld64), 64'd1);
      @(negedge clk);
      #1 chk("bp drained", 64'(vld64), 64'd0);

      // ---------------- serialisation on a load ----------------
      @(negedge clk);
      in_valid = 1'b1; in_instrux = LD_X6;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("ld busy64",     64'(busy64), 64'd1);
      chk("ld in_ready",   64'(rdy64),  64'd0);
      chk("ld memread",    64'(mr64),   64'd1);
      chk("ld imm",        imm64,       64'd8);
      chk("ld busy32",     64'(busy32), 64'd0);
      repeat (2) @(negedge clk);
      #1 chk("ld still waiting", 64'(rdy64), 64'd0);
      serial_done = 1'b1;
      @(negedge clk);
      serial_done = 1'b0;
      #1;
      chk("ld released busy",  64'(busy64), 64'd0);
      chk("ld released ready", 64'(rdy64),  64'd1);

      // ---------------- flush together with serial_done while in WAIT ----------------
      @(negedge clk);
      in_valid = 1'b1; in_instrux = LD_X6;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b1; serial_done = 1'b1;
      @(negedge clk);
      flush = 1'b0; serial_done = 1'b0;
      #1;
      chk("flush+done busy",  64'(busy64), 64'd0);
      chk("flush+done valid", 64'(vld64),  64'd0);

      // ---------------- flush with output register and skid both full ----------------
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_instrux = ADDI_X5;
      @(negedge clk);
      in_instrux = ADDI_X6;
      @(negedge clk);
      flush = 1'b1; in_instrux = ADDI_X7;
      #1;
      chk("fl full valid",   64'(vld64), 64'd1);
      chk("fl no accept",    64'(rdy64), 64'd0);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("fl out_valid",    64'(vld64), 64'd0);
      chk("fl in_ready",     64'(rdy64), 64'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1 chk($sformatf("fl no emit %0d", k), 64'(vld64), 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised RV64/RV32 integer decode stage that sits between fetch and register-read/execute.
- Decodes one 32-bit instruction per cycle into register indices, a fully sign-extended XLEN immediate, an 11-bit operation code and control flags.
- Replaces the ad-hoc stall/flush wiring with a valid/ready handshake, a one-entry skid buffer and an explicit serialisation FSM for load/store/ecall.

Parameters:
- XLEN, 64, datapath width; legal values are 32 and 64.
- SHAMT_W, $clog2(XLEN), width of the shift-amount field; derived, not overridable.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode accepts the instruction this cycle.
- in_instrux  in  32  raw instruction.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  branch-taken/redirect; kills all held state.
- serial_done  in  1  pulse from memory/ecall unit that releases serialisation.
- out_valid  out  1  decoded packet valid.
- out_ready  in  1  downstream accepts the packet.
- out_pc  out  XLEN  PC of the packet.
- out_instrux  out  32  raw instruction of the packet.
- out_rs1, out_rs2, out_rd  out  5 each  register indices; 0 when unused.
- out_imm  out  XLEN  sign-extended immediate.
- out_operation  out  11  operation code from decode_pkg.
- out_regwrite, out_memread, out_memwrite, out_is_ecall, out_illegal  out  1 each  control flags.
- serial_busy  out  1  FSM is in WAIT.

Behaviour:
- Reset: every out_* output is 0, out_valid=0, skid empty, FSM=RUN, serial_busy=0.
- in_ready = (state==RUN) && !skid_valid && !flush. Accept when in_valid && in_ready.
- Latency is 1 cycle: an instruction accepted in cycle N is on out_* in cycle N+1 if the output register is free.
- Output register update:
  - On the out_valid && out_ready pop, or when the register is empty, load from skid if skid_valid; otherwise load the newly accepted packet; otherwise clear out_valid.
  - If an accept arrives while the output is held (out_valid && !out_ready), the packet goes to skid.
  - Ordering is strict FIFO.
- out_* payload is stable while out_valid && !out_ready.
- FSM RUN -> WAIT on accepting an instruction whose opcode is 0x03, 0x23 or 0x73.
- FSM WAIT -> RUN on serial_done or flush.
- serial_done arriving while in RUN is ignored.
- flush, highest priority: next cycle out_valid=0, skid empty, FSM=RUN. No accept happens in the flush cycle. flush and serial_done together -> RUN.
- Immediates, all sign-extended from bit 31 to XLEN:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - U: {[31:12],12'b0}.
  - Shifts: zero-extended shamt, [20+SHAMT_W-1:20].
- Illegal instruction: out_illegal=1, operation=0, regwrite/memread/memwrite=0, rs/rd=0, and the packet is still emitted. Illegal cases:
  - Unknown opcode.
  - Unknown funct3/funct7 (including funct3 2,3 in OP-32).
  - RV64 shift funct6 other than 0x00/0x10.
  - XLEN=32 with any of: opcode 0x1b/0x3b, LD, LWU, SD, or shamt[5]=1.
- An illegal packet does not enter WAIT.
- x0 as rd: regwrite stays as decoded; downstream ignores writes to x0.

Optional Feature:
- Macro: RV_M_EN.
- Defined: funct7=0x01 in OP (0x33) decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, and in OP-32 (0x3b) decodes MULW/DIVW/DIVUW/REMW/REMUW (the last group only when XLEN=64).
- Undefined: those encodings raise out_illegal=1.

Decomposition:
- decode_pkg holds:
  - opcode localparams.
  - operation codes as an 11-bit enum, matching the existing operation definitions.
  - decoded_t struct {rs1, rs2, rd, imm, operation, regwrite, memread, memwrite, is_ecall, is_serial, illegal}.
- Sub-module decode_comb (parameter XLEN): purely combinational, instrux -> decoded_t.
- decode_pipe owns the handshake, the skid buffer and the FSM.

Test Plan:
- XLEN=64, accept 0xFFF08293 (addi x5,x1,-1) -> next cycle out_valid=1, op=ADDI, rs1=1, rd=5, imm=0xFFFF_FFFF_FFFF_FFFF, regwrite=1.
- out_ready=0, stream three addi -> first in the output register, second in skid, in_ready=0 on the third; raise out_ready -> packets pop in order over 2 cycles and the third is then accepted.
- Accept 0x00813303 (ld x6,8(x2)) -> memread=1, imm=8, serial_busy=1 and in_ready=0 until a serial_done pulse, in_ready=1 the following cycle.
- Output register and skid full, pulse flush -> next cycle out_valid=0, in_ready=1, no held packet is ever emitted.
- Accept 0xFFDFF0EF (jal x1,-4) -> op=JAL, rd=1, imm=0xFFFF_FFFF_FFFF_FFFC; XLEN=32 gives imm=0xFFFF_FFFC.
- XLEN=32 with 0x00813303, and 0x02B50533 (mul) without RV_M_EN -> out_illegal=1, regwrite=0, serial_busy stays 0.
